// File: rtl/mux_bist_ctrl.sv
// Purpose : BIST controller for a 2:1 mux cell. Sweeps patterns {c,d,sl} = 0..NPAT-1,
//           compares the mux output to a golden model and reports a registered verdict.
// Latency : done rises 2*NPAT cycles after the start edge (one apply + one capture per pattern).
// Backpressure: none; start is honoured only in IDLE/DONE and ignored while a sweep runs.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             begin a sweep (sampled in IDLE/DONE only)
//   pat_out[2:0]      pattern to the mux under test, {c, d, sl}
//   dut_o             mux output, sampled only in CAPTURE
//   busy / done       sweep in progress / sweep finished
//   pass              err_cnt == 0, valid while done
//   err_cnt           saturating mismatch count for the current sweep
//   fail_valid        at least one mismatch seen
//   first_fail        pattern index of the first mismatch (0 if none)
//   signature         MISR of captured outputs; present only when MUX_BIST_SIG_EN is
//                     defined, otherwise tied to 8'h00
module mux_bist_ctrl #(
    parameter int NPAT  = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [2:0]       pat_out,
    input  logic             dut_o,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic             fail_valid,
    output logic [2:0]       first_fail,
    output logic [7:0]       signature
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_APPLY   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [2:0]       PAT_LAST = 3'(NPAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state_q, state_d;
    logic [2:0]       pat_q, pat_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic             fail_vld_q, fail_vld_d;
    logic [2:0]       first_fail_q, first_fail_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             exp_bit;
    logic             mismatch;
`ifdef MUX_BIST_SIG_EN
    logic [7:0]       sig_q, sig_d;
`endif

    // Golden mux model: o = sl ? c : d, with pattern bits {c, d, sl}.
    assign exp_bit  = pat_q[0] ? pat_q[2] : pat_q[1];
    assign mismatch = (dut_o != exp_bit);

    always_comb begin
        state_d      = state_q;
        pat_d        = pat_q;
        err_d        = err_q;
        fail_vld_d   = fail_vld_q;
        first_fail_d = first_fail_q;
`ifdef MUX_BIST_SIG_EN
        sig_d        = sig_q;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_APPLY;
                    pat_d        = 3'd0;
                    err_d        = '0;
                    fail_vld_d   = 1'b0;
                    first_fail_d = 3'd0;
`ifdef MUX_BIST_SIG_EN
                    sig_d        = 8'h00;
`endif
                end
            end
            // Settle cycle: the mux sees the new pattern before it is sampled.
            S_APPLY: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (mismatch) begin
                    if (err_q != CNT_MAX) begin
                        err_d = err_q + CNT_ONE;
                    end
                    if (!fail_vld_q) begin
                        first_fail_d = pat_q;
                        fail_vld_d   = 1'b1;
                    end
                end
`ifdef MUX_BIST_SIG_EN
                sig_d = {sig_q[6:0], sig_q[7] ^ sig_q[5] ^ sig_q[4] ^ sig_q[3] ^ dut_o};
`endif
                if (pat_q == PAT_LAST) begin
                    state_d = S_DONE;
                end else begin
                    pat_d   = pat_q + 3'd1;
                    state_d = S_APPLY;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status flags are registered from the next state so they line up
        // with the results landing in the same edge.
        busy_d = (state_d == S_APPLY) || (state_d == S_CAPTURE);
        done_d = (state_d == S_DONE);
        pass_d = done_d && (err_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pat_q        <= 3'd0;
            err_q        <= '0;
            fail_vld_q   <= 1'b0;
            first_fail_q <= 3'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pat_q        <= pat_d;
            err_q        <= err_d;
            fail_vld_q   <= fail_vld_d;
            first_fail_q <= first_fail_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
        end
    end

`ifdef MUX_BIST_SIG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 8'h00;
        end else begin
            sig_q <= sig_d;
        end
    end
    assign signature = sig_q;
`else
    assign signature = 8'h00;
`endif

    assign pat_out    = pat_q;
    assign err_cnt    = err_q;
    assign fail_valid = fail_vld_q;
    assign first_fail = first_fail_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;

endmodule
